// File: rtl/sum_bcd_display.sv
// sum_bcd_display: captures a 5-bit adder result, converts it to two BCD digits by double-dabble, and drives two seven-segment displays.
// Define SUM_BCD_BLANK_LEADING_ZERO_EN to blank the tens display when the tens digit is zero.
module sum_bcd_display #(
  parameter int SUM_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [SUM_W-1:0] sum,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic [6:0]       hex1,
  output logic [6:0]       hex0
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_nx;
  logic [12:0] work, work_adj, work_sh;
  logic [2:0] cnt;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = (state == IDLE) ? (start ? CONV : IDLE) :
               (state == CONV) ? (cnt == 3'd4 ? DONE : CONV) : IDLE;
  always_comb begin
    busy = state == CONV;
    done = state == DONE;
  end
  // add-3 on each BCD nibble >= 5, then shift; binary part sits in the low 5 bits
  always_comb begin
    work_adj = {work[12:9] + (work[12:9] >= 4'd5 ? 4'd3 : 4'd0),
                work[8:5] + (work[8:5] >= 4'd5 ? 4'd3 : 4'd0),
                work[4:0]};
    work_sh = work_adj << 1;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      work <= '0;
      cnt <= '0;
      bcd_tens <= '0;
      bcd_ones <= '0;
    end else if (state == IDLE && start) begin
      work <= {{(13-SUM_W){1'b0}}, sum};
      cnt <= '0;
    end else if (state == CONV) begin
      work <= work_sh;
      cnt <= cnt + 3'd1;
      if (cnt == 3'd4) begin
        bcd_tens <= work_sh[12:9];
        bcd_ones <= work_sh[8:5];
      end
    end
  assign hex0 = seg7(bcd_ones);
`ifdef SUM_BCD_BLANK_LEADING_ZERO_EN
  assign hex1 = (bcd_tens == 4'd0) ? 7'b1111111 : seg7(bcd_tens);
`else
  assign hex1 = seg7(bcd_tens);
`endif
endmodule

// File: doc/sum_bcd_display.md
# sum_bcd_display

Sequential binary-to-BCD converter and seven-segment driver placed directly downstream of the lab's 4-bit ripple-carry adder. It captures the adder's 5-bit result (sum plus carry-out, range 0–31) on a start strobe. It converts the result to two BCD digits with an iterative shift-add-3 (double-dabble) engine and drives two active-low seven-segment displays, so the board shows the sum in decimal instead of raw LEDs.

## Interface
- `SUM_W`, default 5: input width. It is fixed at 5; other values are unsupported.
- `clk` input 1: single system clock; all state updates on its rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `start` input 1: convert request, sampled on `clk` edges. The pulse may be one cycle or longer.
- `sum` input 5: adder result, {carry-out, sum[3:0]}; sampled only when `start` is accepted.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: single-cycle pulse when new digits are valid.
- `bcd_tens` output 4: registered tens digit, 0–3.
- `bcd_ones` output 4: registered ones digit, 0–9.
- `hex1` output 7: tens display, active-low segments {g,f,e,d,c,b,a}.
- `hex0` output 7: ones display, same encoding.

## Operation
- FSM states: IDLE, CONV, DONE.
- **IDLE:**
  - If `start` is 1 at an edge, load the 13-bit working register {8'b0, sum}, clear the step counter, and go to CONV.
  - Otherwise stay in IDLE.
- **CONV:** each cycle:
  - For each BCD nibble of the working register that is ≥5, add 3 to that nibble.
  - Then shift the whole register left by 1 and increment the counter.
  - After the 5th shift (counter = 4), load `bcd_tens`/`bcd_ones` from the working register and go to DONE.
- **DONE:** lasts one cycle; `done`=1; then return to IDLE unconditionally.
- `start` outside IDLE (CONV or DONE) is ignored; there is no queueing. A level-held `start` restarts on the first IDLE edge.
- Changes to `sum` after acceptance do not affect the conversion in flight.
- `hex1`/`hex0` are combinational decodes of the registered `bcd_tens`/`bcd_ones`, using active-low codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Digit values 10–15 decode to blank (1111111) defensively.
- The displayed digits hold the last completed conversion until the next DONE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd_tens`=0, `bcd_ones`=0, `hex0`=1000000. `hex1`=1000000, or 1111111 with the macro defined.
- Start accepted at edge E0 → `busy`=1 from E0 through E5.
- At E5, the digits register and the state moves to DONE, so `done`=1 and `busy`=0 in the cycle after E5.
- At E6, the state returns to IDLE. The earliest next acceptance is edge E7.
- Latency: 5 cycles from acceptance to valid digits. Throughput: one conversion per 7 cycles.
- `busy` and `done` are never high together.
- Reset asserted mid-conversion: immediate return to reset values, and the partial result is discarded.

## Configuration
- `SUM_BCD_BLANK_LEADING_ZERO_EN`:
  - Defined: `hex1` shows blank (1111111) whenever `bcd_tens`=0, including at reset.
  - Undefined: `hex1` always shows the decoded digit, so 0 shows 1000000.
  - `bcd_tens` itself is unaffected either way.

## Test plan
- Reset with `resetn`=0 → `busy`=0, `done`=0, `bcd_tens`=0, `bcd_ones`=0, `hex0`=1000000.
- `sum`=31, one-cycle `start` → `done` pulses in the 6th cycle after acceptance; `bcd_tens`=3, `bcd_ones`=1, `hex1`=0110000, `hex0`=1111001.
- Sweep `sum` 0–31, one conversion each → digits equal `sum`/10 and `sum`%10 for every value.
- `sum`=19 accepted; `start` pulsed again with `sum`=7 during CONV and during DONE → both pulses are ignored; the result is 1,9. A subsequent `start` in IDLE yields 0,7.
- `sum`=25 accepted; `resetn` pulled low at the 3rd CONV cycle → outputs return to reset values immediately; no `done` pulse follows.
- With `SUM_BCD_BLANK_LEADING_ZERO_EN` defined, `sum`=9 → `hex1`=1111111, `hex0`=0010000. Without the macro, the same stimulus gives `hex1`=1000000.
